pcie_cc_arbiter: RTL and testbench



---
 rtl/pcie_cc_arbiter.sv | 153 +++++++++++++++
 tb/tb_pcie_cc_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cc_arbiter.sv
// Packet-granular round-robin arbiter feeding the PCIe CC AXI4-Stream port through a 2-entry skid stage.
// Optional per-port completed-packet counters are built when CC_ARB_STATS_EN is defined.
module pcie_cc_arbiter #(
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 256,
  parameter int KEEP_W  = 8,
  parameter int USER_W  = 33
) (
  input  logic                          pcie_clk,
  input  logic                          pcie_reset,
  input  logic [N_PORTS-1:0]            s_cc_tvalid,
  output logic [N_PORTS-1:0]            s_cc_tready,
  input  logic [N_PORTS*DATA_W-1:0]     s_cc_tdata,
  input  logic [N_PORTS*KEEP_W-1:0]     s_cc_tkeep,
  input  logic [N_PORTS*USER_W-1:0]     s_cc_tuser,
  input  logic [N_PORTS-1:0]            s_cc_tlast,
  output logic                          s_axis_cc_tvalid,
  input  logic                          s_axis_cc_tready,
  output logic [DATA_W-1:0]             s_axis_cc_tdata,
  output logic [KEEP_W-1:0]             s_axis_cc_tkeep,
  output logic [USER_W-1:0]             s_axis_cc_tuser,
  output logic                          s_axis_cc_tlast
`ifdef CC_ARB_STATS_EN
  ,
  output logic [N_PORTS*32-1:0]         pkt_count
`endif
);

  // state | meaning
  // IDLE  | no packet owns the output; pick next requester from rr_ptr
  // BUSY  | port `grant` owns the output until its tlast beat is accepted
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int IDX_W  = $clog2(N_PORTS);
  localparam int BEAT_W = DATA_W + KEEP_W + USER_W + 1;

  state_t              state;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic [1:0]          count;
  logic [BEAT_W-1:0]   head;
  logic [BEAT_W-1:0]   tail;
  logic [BEAT_W-1:0]   in_beat;
  logic                in_last;
  logic                full;
  logic                accept;
  logic                pop;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_PORTS);
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!sel_found && s_cc_tvalid[wrap_idx(int'(rr_ptr) + i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(int'(rr_ptr) + i);
      end
    end
  end

  assign in_last = s_cc_tlast[grant];
  assign in_beat = {in_last,
                    s_cc_tuser[int'(grant)*USER_W +: USER_W],
                    s_cc_tkeep[int'(grant)*KEEP_W +: KEEP_W],
                    s_cc_tdata[int'(grant)*DATA_W +: DATA_W]};

  assign full   = (count == 2'd2);
  assign accept = (state == BUSY) && !full && s_cc_tvalid[grant];
  assign pop    = s_axis_cc_tvalid && s_axis_cc_tready;

  always_comb begin
    s_cc_tready = '0;
    if (state == BUSY && !full) s_cc_tready[grant] = 1'b1;
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant <= sel_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          // a stalled granted port keeps ownership; only its tlast releases it
          if (accept && in_last) begin
            state  <= IDLE;
            rr_ptr <= (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // head is always the beat on the output; tail only holds data while full
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (accept) begin
            head  <= in_beat;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head <= in_beat;
          end else if (accept) begin
            tail  <= in_beat;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign s_axis_cc_tvalid = (count != 2'd0);
  assign {s_axis_cc_tlast, s_axis_cc_tuser, s_axis_cc_tkeep, s_axis_cc_tdata} = head;

`ifdef CC_ARB_STATS_EN
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) begin
      pkt_count <= '0;
    end else if (accept && in_last) begin
      pkt_count[int'(grant)*32 +: 32] <= pkt_count[int'(grant)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_cc_arbiter.sv
// Scoreboard bench for pcie_cc_arbiter with two ports; define CC_ARB_STATS_EN to also exercise the packet counters.
module tb_pcie_cc_arbiter;

  localparam int NP = 2;
  localparam int WAIT_MAX = 300;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   keep;
    logic [32:0]  user;
    logic         last;
  } beat_t;

  logic              pcie_clk = 1'b0;
  logic              pcie_reset;
  logic [NP-1:0]     s_cc_tvalid;
  logic [NP-1:0]     s_cc_tready;
  logic [NP*256-1:0] s_cc_tdata;
  logic [NP*8-1:0]   s_cc_tkeep;
  logic [NP*33-1:0]  s_cc_tuser;
  logic [NP-1:0]     s_cc_tlast;
  logic              s_axis_cc_tvalid;
  logic              s_axis_cc_tready;
  logic [255:0]      s_axis_cc_tdata;
  logic [7:0]        s_axis_cc_tkeep;
  logic [32:0]       s_axis_cc_tuser;
  logic              s_axis_cc_tlast;
`ifdef CC_ARB_STATS_EN
  logic [NP*32-1:0]  pkt_count;
`endif

  logic          tv_p [NP];
  logic [255:0]  td_p [NP];
  logic [7:0]    tk_p [NP];
  logic [32:0]   tu_p [NP];
  logic          tl_p [NP];

  assign s_cc_tvalid = {tv_p[1], tv_p[0]};
  assign s_cc_tdata  = {td_p[1], td_p[0]};
  assign s_cc_tkeep  = {tk_p[1], tk_p[0]};
  assign s_cc_tuser  = {tu_p[1], tu_p[0]};
  assign s_cc_tlast  = {tl_p[1], tl_p[0]};

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t mon_exp;

  always #5 pcie_clk = ~pcie_clk;

  pcie_cc_arbiter #(.N_PORTS(NP), .DATA_W(256), .KEEP_W(8), .USER_W(33)) dut (
    .pcie_clk         (pcie_clk),
    .pcie_reset       (pcie_reset),
    .s_cc_tvalid      (s_cc_tvalid),
    .s_cc_tready      (s_cc_tready),
    .s_cc_tdata       (s_cc_tdata),
    .s_cc_tkeep       (s_cc_tkeep),
    .s_cc_tuser       (s_cc_tuser),
    .s_cc_tlast       (s_cc_tlast),
    .s_axis_cc_tvalid (s_axis_cc_tvalid),
    .s_axis_cc_tready (s_axis_cc_tready),
    .s_axis_cc_tdata  (s_axis_cc_tdata),
    .s_axis_cc_tkeep  (s_axis_cc_tkeep),
    .s_axis_cc_tuser  (s_axis_cc_tuser),
    .s_axis_cc_tlast  (s_axis_cc_tlast)
`ifdef CC_ARB_STATS_EN
    ,
    .pkt_count        (pkt_count)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int p, input int id, input int b, input int nb);
    beat_t  e;
    logic [31:0] w;
    w      = {8'(8'hA0 + p), 8'(id), 8'(b), 8'h5A};
    e.data = {8{w}} ^ 256'(b * 3 + 1);
    e.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
    e.user = {1'b1, 8'(p), 8'(id), 16'(b)};
    e.last = (b == nb - 1);
    return e;
  endfunction

  task automatic push_pkt(input int p, input int id, input int nb);
    for (int b = 0; b < nb; b++) sb.push_back(mk_beat(p, id, b, nb));
  endtask

  task automatic drive_beat(input int p, input int id, input int b, input int nb);
    beat_t e;
    e = mk_beat(p, id, b, nb);
    tv_p[p] = 1'b1;
    td_p[p] = e.data;
    tk_p[p] = e.keep;
    tu_p[p] = e.user;
    tl_p[p] = e.last;
  endtask

  // gap_at < 0 means no mid-packet valid gap
  task automatic send_pkt(input int p, input int id, input int nb, input int gap_at, input int gap_len);
    int n;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_at) begin
        tv_p[p] = 1'b0;
        repeat (gap_len) @(posedge pcie_clk);
        #1;
      end
      drive_beat(p, id, b, nb);
      n = 0;
      forever begin
        @(negedge pcie_clk);
        if (s_cc_tready[p]) break;
        n++;
        if (n > WAIT_MAX) begin
          chk("drv_timeout", 1, 0);
          tv_p[p] = 1'b0;
          return;
        end
      end
      @(posedge pcie_clk);
      #1;
    end
    tv_p[p] = 1'b0;
    tl_p[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge pcie_clk);
    #1;
    pcie_reset = 1'b1;
    repeat (2) @(posedge pcie_clk);
    #1;
    pcie_reset = 1'b0;
  endtask

  always @(negedge pcie_clk) begin
    if (s_axis_cc_tvalid && s_axis_cc_tready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_data", s_axis_cc_tdata, mon_exp.data);
        chk("out_keep", s_axis_cc_tkeep, mon_exp.keep);
        chk("out_user", s_axis_cc_tuser, mon_exp.user);
        chk("out_last", s_axis_cc_tlast, mon_exp.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]  mask;
    logic         p1_done;
    logic         bad;
    logic [255:0] held;

    pcie_reset = 1'b1;
    s_axis_cc_tready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      tv_p[i] = 1'b0; td_p[i] = '0; tk_p[i] = '0; tu_p[i] = '0; tl_p[i] = 1'b0;
    end
    repeat (3) @(posedge pcie_clk);
    #1;
    pcie_reset = 1'b0;
    @(negedge pcie_clk);
    chk("rst_in_ready", s_cc_tready, 0);
    chk("rst_out_valid", s_axis_cc_tvalid, 0);
    chk("rst_out_data", s_axis_cc_tdata, 0);
    chk("rst_out_keep", s_axis_cc_tkeep, 0);
    chk("rst_out_user", s_axis_cc_tuser, 0);
    chk("rst_out_last", s_axis_cc_tlast, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);

    // single 3-beat packet from port 0: latency and rr_ptr advance
    @(posedge pcie_clk);
    #1;
    push_pkt(0, 1, 3);
    fork
      send_pkt(0, 1, 3, -1, 0);
      begin
        @(negedge pcie_clk); chk("t1_c0_ready", s_cc_tready, 2'b00);
        @(negedge pcie_clk); chk("t1_c1_ready", s_cc_tready, 2'b01);
                             chk("t1_c1_oval", s_axis_cc_tvalid, 0);
        @(negedge pcie_clk); chk("t1_c2_oval", s_axis_cc_tvalid, 1);
        @(negedge pcie_clk);
        @(negedge pcie_clk); chk("t1_c4_oval", s_axis_cc_tvalid, 1);
        @(negedge pcie_clk); chk("t1_c5_oval", s_axis_cc_tvalid, 0);
      end
    join
    repeat (3) @(posedge pcie_clk);
    chk("t1_rr_ptr", dut.rr_ptr, 1);

    // both ports continuously valid: order 0,1,0,1 with one bubble per packet
    do_reset();
    @(posedge pcie_clk);
    #1;
    push_pkt(0, 20, 2); push_pkt(1, 21, 2); push_pkt(0, 22, 2); push_pkt(1, 23, 2);
    mask = '0;
    fork
      begin send_pkt(0, 20, 2, -1, 0); send_pkt(0, 22, 2, -1, 0); end
      begin send_pkt(1, 21, 2, -1, 0); send_pkt(1, 23, 2, -1, 0); end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge pcie_clk);
          mask[i] = |(s_cc_tvalid & s_cc_tready);
        end
      end
    join
    chk("t2_accept_pattern", mask, 12'hDB6);
    repeat (4) @(posedge pcie_clk);

    // port 1 holds grant through a 5-cycle valid gap while port 0 waits
    #1;
    push_pkt(1, 30, 3); push_pkt(0, 31, 2);
    p1_done = 1'b0;
    bad = 1'b0;
    fork
      begin send_pkt(1, 30, 3, 1, 5); p1_done = 1'b1; end
      begin repeat (2) @(posedge pcie_clk); #1; send_pkt(0, 31, 2, -1, 0); end
      begin
        while (!p1_done) begin
          @(negedge pcie_clk);
          if (s_cc_tready[0]) bad = 1'b1;
        end
      end
    join
    chk("t3_p0_blocked", bad, 0);
    repeat (4) @(posedge pcie_clk);

    // output stalled 10 cycles during a 4-beat packet
    #1;
    s_axis_cc_tready = 1'b0;
    push_pkt(0, 40, 4);
    bad = 1'b0;
    fork
      send_pkt(0, 40, 4, -1, 0);
      begin
        repeat (4) @(negedge pcie_clk);
        chk("t4_full_ready", s_cc_tready, 2'b00);
        chk("t4_full_count", dut.count, 2);
        chk("t4_head_valid", s_axis_cc_tvalid, 1);
        chk("t4_head_data", s_axis_cc_tdata, mk_beat(0, 40, 0, 4).data);
        held = s_axis_cc_tdata;
        repeat (6) begin
          @(negedge pcie_clk);
          if (s_axis_cc_tdata !== held || !s_axis_cc_tvalid || s_cc_tready != 2'b00) bad = 1'b1;
        end
        chk("t4_stable", bad, 0);
        @(posedge pcie_clk);
        #1;
        s_axis_cc_tready = 1'b1;
        @(negedge pcie_clk); chk("t4_ready_at_pop", s_cc_tready, 2'b00);
        @(negedge pcie_clk); chk("t4_ready_after_pop", s_cc_tready, 2'b01);
      end
    join
    repeat (4) @(posedge pcie_clk);

    // reset during the 2nd beat flushes the partial packet
    #1;
    s_axis_cc_tready = 1'b0;
    drive_beat(0, 45, 0, 4);
    @(posedge pcie_clk); #1;
    @(posedge pcie_clk); #1;
    drive_beat(0, 45, 1, 4);
    pcie_reset = 1'b1;
    @(posedge pcie_clk); #1;
    tv_p[0] = 1'b0;
    @(negedge pcie_clk);
    chk("t5_out_valid", s_axis_cc_tvalid, 0);
    chk("t5_out_data", s_axis_cc_tdata, 0);
    chk("t5_out_last", s_axis_cc_tlast, 0);
    chk("t5_in_ready", s_cc_tready, 0);
    chk("t5_state_idle", dut.state, 0);
    pcie_reset = 1'b0;
    s_axis_cc_tready = 1'b1;
    @(posedge pcie_clk); #1;
    push_pkt(1, 51, 2);
    send_pkt(1, 51, 2, -1, 0);
    repeat (4) @(posedge pcie_clk);

`ifdef CC_ARB_STATS_EN
    do_reset();
    force dut.pkt_count = {32'h0000_0000, 32'hFFFF_FFFF};
    @(posedge pcie_clk); #1;
    release dut.pkt_count;
    chk("t6_preload", pkt_count[31:0], 32'hFFFF_FFFF);
    push_pkt(0, 60, 1);
    send_pkt(0, 60, 1, -1, 0);
    chk("t6_wrap", pkt_count[31:0], 0);
    for (int k = 0; k < 3; k++) begin
      push_pkt(1, 61 + k, 2);
      send_pkt(1, 61 + k, 2, -1, 0);
    end
    chk("t6_p1_count", pkt_count[63:32], 3);
    chk("t6_p0_hold", pkt_count[31:0], 0);
    repeat (4) @(posedge pcie_clk);
`endif

    repeat (3) @(posedge pcie_clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
